uart_rx_core: RTL
=================

// Module: uart_rx_core
// PURPOSE
//  RS-232 serial receiver: the input end of the loopback serial path, deserialising rs232_rx
//  into bytes for the switch/LED datapath. Format is 8N1, LSB first, idle-high line.
//  Bit timing uses a 16x oversample tick with mid-bit sampling. Received bytes are presented
//  through a one-entry valid/ready holding register, with framing and overrun reporting.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        9600        line bit rate, bits/s
//  OVERSAMPLE  16          ticks per bit; must be even and >= 4
//  DIV = CLK_FREQ/(BAUD*OVERSAMPLE) (derived, truncated)  clocks per tick; must be >= 2
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  rs232_rx     in   1  asynchronous serial line input
//  rx_data      out  8  received byte; valid while rx_valid=1
//  rx_valid     out  1  holding register full
//  rx_ready     in   1  consumer accepts; transfer occurs when rx_valid & rx_ready
//  frame_err    out  1  one-cycle pulse: stop bit sampled low
//  overrun_err  out  1  one-cycle pulse: byte completed while holding register full
//  busy         out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset=0): rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, FSM=IDLE.
//    Synchroniser FFs reset to 1; tick and bit counters reset to 0; armed=0.
//  - Input path: rs232_rx passes through a 2-FF synchroniser; the FSM uses only the synced level (rxs).
//  - Tick: a free-running counter of 0..DIV-1 pulses tick for one cycle on wrap. In IDLE it is
//    held at 0 so that the first tick follows the start edge by exactly DIV clocks.
//  - armed: set when rxs=1 is seen in IDLE; cleared on leaving IDLE. Start detection requires armed=1,
//    so a line held low through reset or after a framing error never starts a frame.
//  - FSM: IDLE -> START when armed & rxs=0.
//    START: count OVERSAMPLE/2 ticks. If rxs=0 at that tick, go to DATA with bit index 0.
//    Otherwise treat it as a glitch and return to IDLE.
//    DATA: every OVERSAMPLE ticks, sample rxs into shift[idx] (LSB first). After idx 7, go to STOP.
//    STOP: sample after OVERSAMPLE ticks.
//      - rxs=1 -> byte complete; go to IDLE.
//      - rxs=0 -> pulse frame_err for one cycle, discard the byte, go to IDLE with armed=0.
//  - Completion, in the cycle after the stop sample:
//      - rx_valid=0, or rx_valid & rx_ready in that same cycle: load rx_data and set rx_valid=1
//        (consumption and new load coincide; no overrun).
//      - otherwise: keep the old rx_data and rx_valid=1, drop the new byte, pulse overrun_err.
//  - rx_valid clears in the cycle after rx_valid & rx_ready when no completion coincides.
//    rx_data holds its last value while rx_valid=0.
//  - Latency: rx_valid rises 2 (sync) + 1 + DIV*(OVERSAMPLE/2 + 9*OVERSAMPLE) clocks after the
//    line's falling edge (±1 clk detection jitter).
//  - Back-to-back frames: IDLE is re-entered at stop mid-bit, so a start edge arriving half a bit
//    later is caught.
//  - Reset mid-frame: the partial byte is lost; no error pulses are generated.
// TESTING  (CLK_FREQ=1_600_000, BAUD=10_000 -> DIV=10, 160 clk/bit)
//  1. rx_ready=1, send 0x55 8N1 -> rx_data=0x55, rx_valid high exactly 1 cycle,
//     frame_err=overrun_err=0, asserted 1523±1 clk after the start edge.
//  2. Low glitch of 50 clk on an idle line -> busy pulses, then returns to IDLE;
//     no rx_valid or errors; a following 0xC3 is received correctly.
//  3. Send 0xA3 with stop bit forced low, line held low 400 clk, then high
//     -> single frame_err pulse, rx_valid=0, no false frame; a following 0x0F is received.
//  4. rx_ready=0, send 0x12 then 0x34 -> rx_data=0x12 held, overrun_err pulses once at the
//     second stop; raising rx_ready for 1 clk drops rx_valid.
//  5. rx_ready=0, 0x12 pending; the 0x34 completion coincides with a 1-clk rx_ready pulse
//     -> rx_data=0x34, rx_valid=1, no overrun_err.
//  6. reset=0 mid-DATA of 0xFF, line low across release -> all outputs 0 and no frame;
//     then line high, send 0x81, 0x00, 0xFF back-to-back -> all three delivered in order.

Source files
------------

// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle for the serial receiver: the byte holding
// register (data/valid/ready) plus the status pulses and busy flag.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    // Receiver side: produces bytes and status, observes the consumer's ready.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun_err,
        output busy,
        input  rx_ready
    );

    // Consumer side: takes bytes and status, drives ready.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun_err,
        input  busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 serial receiver, LSB first, idle-high line. A 16x (OVERSAMPLE) tick
// drives a start/data/stop FSM that samples mid-bit; finished bytes land in a
// one-entry valid/ready holding register with framing and overrun pulses.
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic     clk,
    input  logic     reset,      // asynchronous, active-low
    input  logic     rs232_rx,
    uart_rx_if.master rx_if
);
    localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OS_W   = $clog2(OVERSAMPLE);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
    localparam logic [OS_W-1:0]   OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_FULL   = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_sync1;
    logic              r_sync2;
    logic [1:0]        r_primed;
    logic [TICK_W-1:0] r_tick_cnt;
    logic [OS_W-1:0]   r_os_cnt;
    logic [OS_W-1:0]   w_os_cnt_next;
    logic [2:0]        r_bit_idx;
    logic [2:0]        w_bit_idx_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_armed;
    logic              w_armed_next;
    logic              w_byte_done;
    logic              w_frame_bad;
    logic              w_rxs;
    logic              w_tick;
    logic              w_line_known;

    logic [7:0]        r_data;
    logic              r_valid;
    logic              r_frame_err;
    logic              r_overrun;

    assign w_rxs        = r_sync2;
    assign w_tick       = (r_tick_cnt == TICK_LAST);
    // The synchroniser resets to 1, which is not a real observation of the
    // line; arming waits until both stages hold genuinely sampled values so a
    // line held low through reset cannot look like a fresh start edge.
    assign w_line_known = r_primed[1];

    // Two-flop synchroniser for the asynchronous line, plus its warm-up flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_primed <= 2'b00;
        end else begin
            r_sync1  <= rs232_rx;
            r_sync2  <= r_sync1;
            r_primed <= {r_primed[0], 1'b1};
        end
    end

    // Oversample tick divider; parked at 0 in IDLE so the first tick lands
    // exactly DIV clocks after the start edge is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (r_state == ST_IDLE || w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    // FSM state and frame-assembly registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_armed   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_os_cnt  <= w_os_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_armed   <= w_armed_next;
        end
    end

    // Next-state logic: start qualification, mid-bit data capture, stop check.
    always_comb begin
        w_state_next   = r_state;
        w_os_cnt_next  = r_os_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_armed_next   = r_armed;
        w_byte_done    = 1'b0;
        w_frame_bad    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_os_cnt_next  = '0;
                w_bit_idx_next = '0;
                if (r_armed && !w_rxs) begin
                    w_state_next = ST_START;
                    w_armed_next = 1'b0;
                end else if (w_rxs && w_line_known) begin
                    w_armed_next = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_HALF) begin
                        w_os_cnt_next = '0;
                        // Still low at mid start bit: genuine start, else glitch.
                        w_state_next  = w_rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        w_os_cnt_next = r_os_cnt + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_FULL) begin
                        w_os_cnt_next           = '0;
                        w_shift_next[r_bit_idx] = w_rxs;
                        if (r_bit_idx == 3'd7) begin
                            w_state_next = ST_STOP;
                        end else begin
                            w_bit_idx_next = r_bit_idx + 1'b1;
                        end
                    end else begin
                        w_os_cnt_next = r_os_cnt + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_os_cnt == OS_FULL) begin
                        // Back to IDLE at mid stop bit so a following start
                        // edge half a bit later is still caught.
                        w_os_cnt_next = '0;
                        w_state_next  = ST_IDLE;
                        if (w_rxs) begin
                            w_byte_done = 1'b1;
                        end else begin
                            w_frame_bad = 1'b1;
                        end
                    end else begin
                        w_os_cnt_next = r_os_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Holding register: load on completion if empty or being drained in the
    // same cycle, otherwise keep the old byte and flag overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_frame_bad;
            r_overrun   <= 1'b0;
            if (w_byte_done) begin
                if (!r_valid || rx_if.rx_ready) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && rx_if.rx_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data     = r_data;
    assign rx_if.rx_valid    = r_valid;
    assign rx_if.frame_err   = r_frame_err;
    assign rx_if.overrun_err = r_overrun;
    assign rx_if.busy        = (r_state != ST_IDLE);
endmodule
